// File: rtl/tone_pkg.sv
// tone_pkg: shared clock constant, frequency-to-cycles helper and measurement FSM states
package tone_pkg;

    localparam int CLK_HZ = 16000000;

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic int hz_to_cycles(input int hz, input int clk_hz = CLK_HZ);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/tone_detector_edge_sync.sv
// edge_sync: two-flop synchroniser plus one-cycle rising-edge pulse for an asynchronous pin
module edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic rise
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures the rising-edge period of PIN_11 and flags tone presence and target match
module tone_detector
    import tone_pkg::*;
#(
    parameter int CLK_HZ         = tone_pkg::CLK_HZ,
    parameter int TARGET_HZ      = 600,
    parameter int TOL_CYCLES     = 267,
    parameter int MATCH_COUNT    = 4,
    parameter int MIN_PERIOD     = 160,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CW             = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PIN_11,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          tone_present,
    output logic          tone_match,
    output logic          glitch
);
    localparam int SW = $clog2(MATCH_COUNT + 1);
    localparam longint TP = longint'(hz_to_cycles(TARGET_HZ, CLK_HZ));
    localparam longint MAXV = (64'sd1 <<< CW) - 1;
    localparam longint LO_I = TP > TOL_CYCLES ? TP - TOL_CYCLES : 0;
    localparam longint HI_I = TP + TOL_CYCLES > MAXV ? MAXV : TP + TOL_CYCLES;
    localparam logic [CW-1:0] WIN_LO = CW'(LO_I > MAXV ? MAXV : LO_I);
    localparam logic [CW-1:0] WIN_HI = CW'(HI_I);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] MC = SW'(MATCH_COUNT);

    logic rise, in_win;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [SW-1:0] streak_q, streak_d;
    logic period_valid_q, period_valid_d;
    logic tone_present_q, tone_present_d;
    logic tone_match_q, tone_match_d;
    logic glitch_q, glitch_d;

    edge_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .din (PIN_11),
        .rise(rise)
    );

    assign in_win = cnt_q >= WIN_LO && cnt_q <= WIN_HI;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        streak_d       = streak_q;
        period_valid_d = 1'b0;
        glitch_d       = 1'b0;
        tone_present_d = tone_present_q;
        if (state_q == IDLE) begin
            cnt_d = rise ? CW'(1) : '0;
            state_d = rise ? MEASURE : IDLE;
        end else if (rise && cnt_q >= MIN_C) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            tone_present_d = 1'b1;
            cnt_d          = CW'(1);
            streak_d       = in_win ? (streak_q == MC ? streak_q : streak_q + 1'b1) : '0;
        end else if (rise) begin
            glitch_d = 1'b1;
            streak_d = '0;
            cnt_d    = cnt_q == TO_C ? cnt_q : cnt_q + 1'b1;
        end else if (cnt_q == TO_C) begin
            state_d        = IDLE;
            tone_present_d = 1'b0;
            streak_d       = '0;
            cnt_d          = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tone_match_d = streak_d == MC;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            streak_q       <= '0;
            period_valid_q <= 1'b0;
            tone_present_q <= 1'b0;
            tone_match_q   <= 1'b0;
            glitch_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            streak_q       <= streak_d;
            period_valid_q <= period_valid_d;
            tone_present_q <= tone_present_d;
            tone_match_q   <= tone_match_d;
            glitch_q       <= glitch_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign tone_present = tone_present_q;
    assign tone_match   = tone_match_q;
    assign glitch       = glitch_q;
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed periods on a scaled clock (TP=266, window 263..269, MIN 100, timeout 1000)
module tb_tone_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin = 1'b0;
    logic [15:0] period;
    logic period_valid, tone_present, tone_match, glitch;
    int errors = 0, checks = 0;
    int cyc = 0, nv = 0, ng = 0, mg = -1, last_p = -1;
    int p_at[32], m_at[32];
    int cv, fall, m_before;

    tone_detector #(
        .CLK_HZ(160000), .TARGET_HZ(600), .TOL_CYCLES(3), .MATCH_COUNT(4),
        .MIN_PERIOD(100), .TIMEOUT_CYCLES(1000), .CW(16)
    ) dut (
        .CLK(clk), .RST(rst), .PIN_11(pin), .period(period), .period_valid(period_valid),
        .tone_present(tone_present), .tone_match(tone_match), .glitch(glitch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input logic p);
        pin = p;
        @(posedge clk);
        #1;
        cyc++;
        if (period_valid) begin
            if (nv < 32) begin
                p_at[nv] = int'(period);
                m_at[nv] = int'(tone_match);
            end
            nv++;
            last_p = int'(period);
        end
        if (glitch) begin
            ng++;
            mg = int'(tone_match);
        end
    endtask

    task automatic wave(input int n, input int per, input int hi);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) step(i < hi);
    endtask

    task automatic clr();
        nv = 0;
        ng = 0;
        mg = -1;
    endtask

    initial begin
        repeat (3) step(0);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_present", int'(tone_present), 0);
        check("rst_match", int'(tone_match), 0);
        check("rst_glitch", int'(glitch), 0);
        rst = 1'b0;
        repeat (3) step(0);
        clr();
        wave(5, 266, 133);
        check("lock_count", nv, 4);
        check("lock_period", last_p, 266);
        check("lock_p0", p_at[0], 266);
        check("lock_m2", m_at[2], 0);
        check("lock_m3", m_at[3], 1);
        check("lock_present", int'(tone_present), 1);
        clr();
        wave(2, 228, 114);
        check("f700_count", nv, 2);
        check("f700_m0", m_at[0], 1);
        check("f700_p1", p_at[1], 228);
        check("f700_drop", m_at[1], 0);
        wave(5, 228, 114);
        check("f700_period", last_p, 228);
        check("f700_match", int'(tone_match), 0);
        check("f700_present", int'(tone_present), 1);
        wave(4, 266, 133);
        cv = -1;
        fall = -1;
        m_before = -1;
        for (int i = 0; i < 1400 && fall < 0; i++) begin
            step(1);
            if (period_valid && cv < 0) begin
                cv = cyc;
                m_before = int'(tone_match);
            end
            if (cv >= 0 && !tone_present && fall < 0) fall = cyc;
        end
        check("to_locked", m_before, 1);
        check("to_delay", fall - cv, 1000);
        check("to_match", int'(tone_match), 0);
        check("to_hold", int'(period), 266);
        repeat (5) step(0);
        wave(5, 266, 133);
        check("gl_lock", int'(tone_match), 1);
        clr();
        for (int i = 0; i < 266; i++) step(i < 20 || (i >= 50 && i < 70));
        wave(4, 266, 133);
        check("gl_count", ng, 1);
        check("gl_m0", m_at[0], 1);
        check("gl_drop", mg, 0);
        check("gl_p1", p_at[1], 266);
        check("gl_m1", m_at[1], 0);
        check("gl_m3", m_at[3], 0);
        check("gl_relock", m_at[4], 1);
        clr();
        wave(5, 266, 27);
        check("duty_count", nv, 5);
        check("duty_period", last_p, 266);
        check("duty_match", int'(tone_match), 1);
        clr();
        wave(1, 269, 27);
        wave(1, 270, 27);
        wave(4, 263, 27);
        wave(1, 262, 27);
        repeat (5) step(1);
        check("win_count", nv, 8);
        check("win_p1", p_at[1], 269);
        check("win_hi_in", m_at[1], 1);
        check("win_p2", p_at[2], 270);
        check("win_hi_out", m_at[2], 0);
        check("win_lo_m5", m_at[5], 0);
        check("win_lo_in", m_at[6], 1);
        check("win_lo_out", m_at[7], 0);
        repeat (40) step(0);
        #2 rst = 1'b1;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_present", int'(tone_present), 0);
        check("arst_match", int'(tone_match), 0);
        check("arst_valid", int'(period_valid), 0);
        clr();
        step(0);
        step(0);
        rst = 1'b0;
        repeat (3) step(0);
        wave(1, 266, 133);
        check("arst_first", nv, 0);
        wave(1, 266, 133);
        check("arst_second", nv, 1);
        check("arst_period2", last_p, 266);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        repeat (4) step(0);
        clr();
        wave(10, 3, 1);
        repeat (4) step(0);
        check("fast_glitch", ng, 9);
        check("fast_valid", nv, 0);
        check("fast_present", int'(tone_present), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
